// File: rtl/lsu_ctrl.sv
// Load/store unit: issues word-aligned memory cycles for one pipeline request at a time,
// with lane extraction on loads and read-modify-write for byte/half stores.
module lsu_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_re,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_wr,
  output logic [WIDTH-1:0] mem_wdata
);

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3BU = 3'b100;
  localparam logic [2:0] F3HU = 3'b101;

  localparam logic [WIDTH-3:0] MemWords = (WIDTH-2)'(MEM_SIZE);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e      state;
  logic        lat_store;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_lane;
  logic [15:0] lat_wdata;

  logic accept;
  logic req_err;
  logic req_is_sw;

  assign accept    = req_valid && req_ready;
  assign req_is_sw = req_store && (req_funct3 == F3W);

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      F3B:     req_err = 1'b0;
      F3H:     req_err = req_addr[0];
      F3W:     req_err = |req_addr[1:0];
      F3BU:    req_err = req_store;
      F3HU:    req_err = req_store | req_addr[0];
      default: req_err = 1'b1;
    endcase
    if (req_addr[WIDTH-1:2] >= MemWords) begin
      req_err = 1'b1;
    end
  end

  function automatic logic [WIDTH-1:0] load_extract(input logic [WIDTH-1:0] word,
                                                    input logic [1:0]       lane,
                                                    input logic [2:0]       funct3);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [WIDTH-1:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3B:     r = {{24{b[7]}}, b};
      F3H:     r = {{16{h[15]}}, h};
      F3BU:    r = {24'b0, b};
      F3HU:    r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Old word with the addressed byte or half replaced by the low store data.
  function automatic logic [WIDTH-1:0] store_merge(input logic [WIDTH-1:0] old,
                                                   input logic [1:0]       lane,
                                                   input logic [2:0]       funct3,
                                                   input logic [15:0]      wdata);
    logic [WIDTH-1:0] r;
    r = old;
    if (funct3 == F3H) begin
      if (lane[1]) r[31:16] = wdata;
      else         r[15:0]  = wdata;
    end else begin
      case (lane)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_re     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lat_store  <= 1'b0;
      lat_funct3 <= '0;
      lat_lane   <= '0;
      lat_wdata  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            lat_store  <= req_store;
            lat_funct3 <= req_funct3;
            lat_lane   <= req_addr[1:0];
            lat_wdata  <= req_wdata[15:0];
            req_ready  <= 1'b0;
            if (req_err) begin
              state      <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_is_sw) begin
              state     <= StWr;
              mem_wr    <= 1'b1;
              mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
              mem_wdata <= req_wdata;
            end else begin
              // Loads and sub-word stores both start with a read of the word.
              state    <= StRd;
              mem_re   <= 1'b1;
              mem_addr <= {req_addr[WIDTH-1:2], 2'b00};
            end
          end
        end
        StRd: begin
          mem_re <= 1'b0;
          if (lat_store) begin
            state     <= StWr;
            mem_wr    <= 1'b1;
            mem_wdata <= store_merge(mem_rdata, lat_lane, lat_funct3, lat_wdata);
          end else begin
            state      <= StResp;
            mem_addr   <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= load_extract(mem_rdata, lat_lane, lat_funct3);
          end
        end
        StWr: begin
          state      <= StResp;
          mem_wr     <= 1'b0;
          mem_addr   <= '0;
          mem_wdata  <= '0;
          resp_valid <= 1'b1;
        end
        StResp: begin
          state      <= StIdle;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= StIdle;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          mem_re     <= 1'b0;
          mem_wr     <= 1'b0;
          mem_addr   <= '0;
          mem_wdata  <= '0;
        end
      endcase
    end
  end

endmodule
